z80_bus_bridge: RTL and testbench
=================================

# z80_bus_bridge

Bus-side responder that sits directly on the tb side of the z80_if pin bundle, downstream of the CPU core. It decodes Z80 memory, I/O and interrupt-acknowledge cycles from the raw strobes and holds the CPU with nWAIT. It converts each cycle into a single req/ack transaction on a simple synchronous backing-store port, then drives read data (or the interrupt vector) back onto the data bus.

## Interface
- MIN_WAIT, 1: minimum CLK cycles nWAIT stays low per cycle, counted from ARM entry; range 0..255.
- TIMEOUT, 255: CLK cycles in REQ without mem_ack before forced completion; range 1..65535.
- CLK  in  1  system clock, the same clock as the CPU.
- RESET  in  1  synchronous, active-high reset.
- nM1, nMREQ, nIORQ, nRD, nWR, nRFSH  in  1 each  CPU bus strobes, active-low.
- A  in  16  CPU address.
- D_in  in  8  sampled data bus.
- D_out  out  8  data to drive onto the bus.
- D_oe  out  1  tristate enable for D; the top-level ties D_out/D_oe to interface D.
- nWAIT  out  1  wait request to the CPU, active-low.
- int_vector  in  8  byte returned during INTA.
- mem_req  out  1  backing-store request, level.
- mem_we  out  1  1 = write.
- mem_io  out  1  1 = I/O space, 0 = memory.
- mem_addr  out  16  latched address.
- mem_wdata  out  8  latched write data.
- mem_ack  in  1  completion, sampled at CLK rise.
- mem_rdata  in  8  valid when mem_ack = 1.
- err_timeout  out  1  one-cycle pulse on timeout.

## Operation
- Reset values: nWAIT=1, D_oe=0, D_out=8'h00, mem_req=0, mem_we=0, mem_io=0, mem_addr=0, mem_wdata=0, err_timeout=0, state IDLE, counters 0.
- All inputs are sampled at the CLK rising edge. All outputs are registered.
- Cycle start:
  - Memory start: nMREQ=0 and nRFSH=1.
  - I/O start: nIORQ=0.
  - INTA: nM1=0 and nIORQ=0.
  - Refresh (nRFSH=0) is ignored.
- States:
  - IDLE: on start → ARM. Latch A into mem_addr. Set mem_io=~nIORQ. Set inta flag. Clear wait counter.
  - ARM: nWAIT=0.
    - INTA: load vector into the data register → DONE.
    - nRD=0: mem_we=0 → REQ.
    - nWR=0: latch D_in into mem_wdata, mem_we=1 → REQ.
    - nMREQ=1 and nIORQ=1 with no direction seen: aborted cycle → IDLE.
  - REQ: mem_req=1.
    - mem_ack=1: capture mem_rdata (reads only), mem_req=0 → DONE.
    - TIMEOUT consecutive cycles without ack: data=8'hFF, err_timeout pulse, mem_req=0 → DONE.
  - DONE:
    - nWAIT=0 while the wait counter < MIN_WAIT, else nWAIT=1.
    - D_oe=1 only for a read with nRD=0, or for INTA with nIORQ=0.
    - D_oe drops the cycle after either strobe rises.
    - When nMREQ=1 and nIORQ=1 → IDLE.
- The wait counter runs from ARM entry and saturates at 255. The timeout counter is 16-bit, cleared on REQ entry.
- Simultaneous ack and timeout in the same cycle: ack wins, no err pulse.
- nRD and nWR both low in ARM: treated as a read.
- RESET mid-cycle: every output returns to its reset value at the next edge and state goes to IDLE. The bus transaction in progress is dropped without an ack.

## Timing
- Strobe first sampled low at edge t → ARM at t. nWAIT is low after edge t, ahead of the CPU's T2 wait sample.
- Direction seen at edge t+1 → mem_req high after t+1.
- Zero-latency memory (ack at first REQ edge, t+2) → DONE at t+2.
- MIN_WAIT=1: nWAIT is high after t+2, so nWAIT is low for 2 cycles.
- mem_req remains asserted until the edge that samples mem_ack. Addr, we, io and wdata are stable for that whole interval.
- Back-to-back cycles: a new start is evaluated in IDLE only. The minimum gap is one cycle with both strobes high.

## Structure
- Package z80_bridge_pkg:
  - state enum {IDLE, ARM, REQ, DONE}.
  - cycle-type enum {CYC_MEM, CYC_IO, CYC_INTA}.
  - constant FLOAT_DATA = 8'hFF.
- Sub-module z80_bridge_timer: wait counter and timeout counter, with clear/enable inputs and outputs wait_met and timed_out.

## Test plan
- Memory read, A=16'h1234, mem_ack on first REQ cycle with rdata=8'h5A, MIN_WAIT=1 → mem_req for 1 cycle with mem_we=0, mem_io=0, mem_addr=16'h1234; D_out=8'h5A with D_oe=1 while nRD=0; nWAIT low for 2 cycles.
- I/O write, A=16'h00FE, D=8'hC3, ack delayed 5 cycles → mem_io=1, mem_we=1, mem_wdata=8'hC3; nWAIT low for 7 cycles.
- INTA with int_vector=8'hFF → no mem_req; D_out=8'hFF driven while nIORQ=0; nWAIT released after MIN_WAIT.
- No ack, TIMEOUT=4 → err_timeout single pulse 4 cycles after mem_req rises; D_out=8'hFF; nWAIT released.
- RESET asserted in REQ → next edge: mem_req=0, nWAIT=1, D_oe=0. A following read completes normally.
- Refresh cycle (nMREQ=0, nRFSH=0) and aborted cycle (strobe pulse with no nRD/nWR) → no mem_req; nWAIT high again within 1 cycle.

Source files
------------

// File: rtl/z80_bridge_pkg.sv
// rtl/z80_bridge_pkg.sv - shared types and constants for the Z80 bus bridge
package z80_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        REQ,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        CYC_MEM,
        CYC_IO,
        CYC_INTA
    } cyc_e;

    // Value returned to the CPU when the backing store never answers
    localparam logic [7:0] FLOAT_DATA = 8'hFF;

endpackage

// File: rtl/z80_bridge_timer.sv
// rtl/z80_bridge_timer.sv - wait-length counter and request timeout counter
module z80_bridge_timer #(
    parameter int MIN_WAIT = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic wait_clr,
    input  logic wait_en,
    input  logic to_clr,
    input  logic to_en,
    output logic wait_met,
    output logic timed_out
);

    localparam logic [7:0]  WAIT_MIN = 8'(MIN_WAIT);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;

    // Next-count logic: clear wins, both counters saturate instead of wrapping
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (wait_clr) begin
            wait_cnt_d = '0;
        end else if (wait_en && (wait_cnt_q != 8'hFF)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
        to_cnt_d = to_cnt_q;
        if (to_clr) begin
            to_cnt_d = '0;
        end else if (to_en && (to_cnt_q != 16'hFFFF)) begin
            to_cnt_d = to_cnt_q + 16'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign wait_met  = (wait_cnt_q >= WAIT_MIN);
    // Fires on the TIMEOUT-th REQ edge: the count was cleared on REQ entry
    assign timed_out = to_en && (to_cnt_q == TO_LAST);

endmodule

// File: rtl/z80_bus_bridge.sv
// rtl/z80_bus_bridge.sv - Z80 bus responder turning CPU cycles into req/ack transactions
module z80_bus_bridge
    import z80_bridge_pkg::*;
#(
    parameter int MIN_WAIT = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        nM1,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nRFSH,
    input  logic [15:0] A,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    output logic        nWAIT,
    input  logic [7:0]  int_vector,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_io,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        err_timeout
);

    state_e      state_q, state_d;
    cyc_e        cyc_q, cyc_d;
    logic        n_wait_q, n_wait_d;
    logic        d_oe_q, d_oe_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_io_q, mem_io_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        err_q, err_d;

    logic wait_clr, to_clr, wait_met, timed_out;
    logic cycle_start, strobes_idle, read_cycle;

    z80_bridge_timer #(
        .MIN_WAIT (MIN_WAIT),
        .TIMEOUT  (TIMEOUT)
    ) u_timer (
        .clk       (CLK),
        .reset     (RESET),
        .wait_clr  (wait_clr),
        .wait_en   (state_q != IDLE),
        .to_clr    (to_clr),
        .to_en     (state_q == REQ),
        .wait_met  (wait_met),
        .timed_out (timed_out)
    );

    // Refresh cycles assert nMREQ too, so they are masked out by nRFSH
    assign cycle_start  = (!nMREQ && nRFSH) || !nIORQ;
    assign strobes_idle = nMREQ && nIORQ;
    assign read_cycle   = (cyc_q != CYC_INTA) && !mem_we_q;

    // Cycle FSM next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        n_wait_d    = n_wait_q;
        d_oe_d      = d_oe_q;
        d_out_d     = d_out_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_io_d    = mem_io_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = 1'b0;
        wait_clr    = 1'b0;
        to_clr      = 1'b0;
        case (state_q)
            IDLE: begin
                n_wait_d = 1'b1;
                d_oe_d   = 1'b0;
                if (cycle_start) begin
                    state_d    = ARM;
                    n_wait_d   = 1'b0;
                    mem_addr_d = A;
                    mem_io_d   = !nIORQ;
                    cyc_d      = (!nM1 && !nIORQ) ? CYC_INTA : (!nIORQ ? CYC_IO : CYC_MEM);
                    wait_clr   = 1'b1;
                end
            end
            ARM: begin
                n_wait_d = 1'b0;
                if (cyc_q == CYC_INTA) begin
                    d_out_d  = int_vector;
                    state_d  = DONE;
                    n_wait_d = wait_met;
                    d_oe_d   = !nIORQ;
                end else if (!nRD) begin
                    // nRD wins when both direction strobes are low
                    mem_we_d  = 1'b0;
                    mem_req_d = 1'b1;
                    to_clr    = 1'b1;
                    state_d   = REQ;
                end else if (!nWR) begin
                    mem_wdata_d = D_in;
                    mem_we_d    = 1'b1;
                    mem_req_d   = 1'b1;
                    to_clr      = 1'b1;
                    state_d     = REQ;
                end else if (strobes_idle) begin
                    state_d  = IDLE;
                    n_wait_d = 1'b1;
                end
            end
            REQ: begin
                n_wait_d = 1'b0;
                // An ack on the timeout edge still counts as a normal completion
                if (mem_ack || timed_out) begin
                    if (mem_ack) begin
                        if (!mem_we_q) begin
                            d_out_d = mem_rdata;
                        end
                    end else begin
                        d_out_d = FLOAT_DATA;
                        err_d   = 1'b1;
                    end
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    n_wait_d  = wait_met;
                    d_oe_d    = !mem_we_q && !nRD;
                end
            end
            DONE: begin
                n_wait_d = wait_met;
                d_oe_d   = (cyc_q == CYC_INTA) ? !nIORQ : (read_cycle && !nRD);
                if (strobes_idle) begin
                    state_d  = IDLE;
                    n_wait_d = 1'b1;
                    d_oe_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any transaction in flight
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            cyc_q       <= CYC_MEM;
            n_wait_q    <= 1'b1;
            d_oe_q      <= 1'b0;
            d_out_q     <= 8'h00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_io_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            n_wait_q    <= n_wait_d;
            d_oe_q      <= d_oe_d;
            d_out_q     <= d_out_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_io_q    <= mem_io_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
        end
    end

    assign nWAIT       = n_wait_q;
    assign D_oe        = d_oe_q;
    assign D_out       = d_out_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_io      = mem_io_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_z80_bus_bridge.sv
// tb/tb_z80_bus_bridge.sv - scoreboard bench for z80_bus_bridge
module tb_z80_bus_bridge;

    localparam int K_MRD  = 0;
    localparam int K_MWR  = 1;
    localparam int K_IOWR = 2;
    localparam int K_INTA = 3;
    localparam int K_MRW  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh;
    logic [15:0] a;
    logic [7:0]  d_in, int_vector;

    logic [7:0]  d_out [2];
    logic        d_oe [2];
    logic        n_wait [2];
    logic        mem_req [2];
    logic        mem_we [2];
    logic        mem_io [2];
    logic [15:0] mem_addr [2];
    logic [7:0]  mem_wdata [2];
    logic        err [2];

    logic        mem_ack_0;
    logic [7:0]  mem_rdata_0;
    logic        mem_ack_1;
    logic [7:0]  mem_rdata_1;

    assign mem_ack_1   = 1'b0;
    assign mem_rdata_1 = 8'h00;

    always #5 clk = ~clk;

    // Responding backing store
    z80_bus_bridge #(.MIN_WAIT(1), .TIMEOUT(16)) u_dut (
        .CLK(clk), .RESET(rst), .nM1(n_m1), .nMREQ(n_mreq), .nIORQ(n_iorq),
        .nRD(n_rd), .nWR(n_wr), .nRFSH(n_rfsh), .A(a), .D_in(d_in),
        .D_out(d_out[0]), .D_oe(d_oe[0]), .nWAIT(n_wait[0]), .int_vector(int_vector),
        .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_io(mem_io[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_ack(mem_ack_0), .mem_rdata(mem_rdata_0), .err_timeout(err[0])
    );

    // Silent backing store: every transaction times out
    z80_bus_bridge #(.MIN_WAIT(3), .TIMEOUT(4)) u_dut_tmo (
        .CLK(clk), .RESET(rst), .nM1(n_m1), .nMREQ(n_mreq), .nIORQ(n_iorq),
        .nRD(n_rd), .nWR(n_wr), .nRFSH(n_rfsh), .A(a), .D_in(d_in),
        .D_out(d_out[1]), .D_oe(d_oe[1]), .nWAIT(n_wait[1]), .int_vector(int_vector),
        .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_io(mem_io[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_ack(mem_ack_1), .mem_rdata(mem_rdata_1), .err_timeout(err[1])
    );

    typedef struct {
        int req;
        int we;
        int io;
        int addr;
        int wdata;
        int has_data;
        int data;
        int wait_lo;
        int err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad = 0;
    int   ack_dly = 0;
    logic [7:0] rdata_val = 8'h00;
    int   rc = 0;
    bit   active = 0;
    int   o_req [2], o_wait [2], o_oe [2], o_err [2];
    int   o_we [2], o_io [2], o_addr [2], o_wdata [2], o_data [2];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int req, input int we, input int io, input int addr,
                                input int wdata, input int has_data, input int data,
                                input int wait_lo, input int err_n);
        exp_t e;
        e.req = req; e.we = we; e.io = io; e.addr = addr; e.wdata = wdata;
        e.has_data = has_data; e.data = data; e.wait_lo = wait_lo; e.err = err_n;
        return e;
    endfunction

    task automatic clear_obs();
        for (int k = 0; k < 2; k++) begin
            o_req[k] = 0; o_wait[k] = 0; o_oe[k] = 0; o_err[k] = 0;
            o_we[k] = 0; o_io[k] = 0; o_addr[k] = 0; o_wdata[k] = 0; o_data[k] = 0;
        end
    endtask

    task automatic compare(input int k, input exp_t e);
        string p;
        p = (k == 0) ? "main" : "tmo";
        check({p, "_req_cycles"}, o_req[k], e.req);
        if (e.req > 0) begin
            check({p, "_mem_we"}, o_we[k], e.we);
            check({p, "_mem_io"}, o_io[k], e.io);
            check({p, "_mem_addr"}, o_addr[k], e.addr);
            if (e.we != 0) check({p, "_mem_wdata"}, o_wdata[k], e.wdata);
        end
        if (e.has_data != 0) begin
            check({p, "_d_oe_seen"}, int'(o_oe[k] > 0), 1);
            check({p, "_d_out"}, o_data[k], e.data);
        end else begin
            check({p, "_d_oe_cycles"}, o_oe[k], 0);
        end
        check({p, "_nwait_low_cycles"}, o_wait[k], e.wait_lo);
        check({p, "_err_pulses"}, o_err[k], e.err);
    endtask

    // Monitor: accumulate what each DUT shows during one bus cycle, score at its end
    initial begin
        clear_obs();
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0;
                clear_obs();
            end else begin
                if (!active && (!n_mreq || !n_iorq)) active = 1;
                if (active) begin
                    for (int k = 0; k < 2; k++) begin
                        if (mem_req[k]) begin
                            if (o_req[k] == 0) begin
                                o_we[k] = int'(mem_we[k]); o_io[k] = int'(mem_io[k]);
                                o_addr[k] = int'(mem_addr[k]); o_wdata[k] = int'(mem_wdata[k]);
                            end
                            o_req[k]++;
                        end
                        if (!n_wait[k]) o_wait[k]++;
                        if (d_oe[k]) begin
                            o_oe[k]++;
                            o_data[k] = int'(d_out[k]);
                        end
                        if (err[k]) o_err[k]++;
                    end
                    if (n_mreq && n_iorq && n_wait[0] && n_wait[1] && !d_oe[0] && !d_oe[1]
                        && !mem_req[0] && !mem_req[1]) begin
                        check("expectation_available", int'(q0.size() > 0 && q1.size() > 0), 1);
                        if (q0.size() > 0 && q1.size() > 0) begin
                            compare(0, q0.pop_front());
                            compare(1, q1.pop_front());
                        end
                        active = 0;
                        clear_obs();
                    end
                end
            end
        end
    end

    // Backing store for the main DUT: ack after ack_dly REQ cycles, never if negative
    initial begin
        mem_ack_0 = 1'b0;
        mem_rdata_0 = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_req[0]) begin
                rc++;
                if (ack_dly >= 0 && rc > ack_dly) begin
                    mem_ack_0 = 1'b1;
                    mem_rdata_0 = rdata_val;
                end
            end else begin
                rc = 0;
                mem_ack_0 = 1'b0;
                mem_rdata_0 = 8'h00;
            end
        end
    end

    task automatic set_idle();
        n_m1 = 1'b1; n_mreq = 1'b1; n_iorq = 1'b1;
        n_rd = 1'b1; n_wr = 1'b1; n_rfsh = 1'b1;
    endtask

    task automatic bus_cycle(input int kind, input logic [15:0] addr, input logic [7:0] wd,
                             input int dly, input logic [7:0] rd);
        int n;
        ack_dly = dly;
        rdata_val = rd;
        @(posedge clk); #1;
        a = addr;
        d_in = wd;
        case (kind)
            K_MRD:   begin n_mreq = 1'b0; n_rd = 1'b0; end
            K_MWR:   begin n_mreq = 1'b0; n_wr = 1'b0; end
            K_IOWR:  begin n_iorq = 1'b0; n_wr = 1'b0; end
            K_INTA:  begin n_m1 = 1'b0; n_iorq = 1'b0; end
            default: begin n_mreq = 1'b0; n_rd = 1'b0; n_wr = 1'b0; end
        endcase
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(n_wait[0] && n_wait[1]) && n < 60);
        if (n >= 60) check("nwait_release_bound", n, 59);
        @(posedge clk); #1;
        set_idle();
        repeat (3) @(posedge clk);
    endtask

    task automatic short_cycle(input logic refresh, input logic [15:0] addr);
        @(posedge clk); #1;
        a = addr;
        n_mreq = 1'b0;
        n_rfsh = !refresh;
        @(posedge clk); #1;
        set_idle();
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int n;
        set_idle();
        a = 16'h0000; d_in = 8'h00; int_vector = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_nwait", int'(n_wait[k]), 1);
            check("reset_d_oe", int'(d_oe[k]), 0);
            check("reset_d_out", int'(d_out[k]), 0);
            check("reset_mem_req", int'(mem_req[k]), 0);
            check("reset_mem_we", int'(mem_we[k]), 0);
            check("reset_mem_io", int'(mem_io[k]), 0);
            check("reset_mem_addr", int'(mem_addr[k]), 0);
            check("reset_mem_wdata", int'(mem_wdata[k]), 0);
            check("reset_err", int'(err[k]), 0);
        end

        q0.push_back(mk(1, 0, 0, 'h1234, 0, 1, 'h5A, 2, 0));
        q1.push_back(mk(4, 0, 0, 'h1234, 0, 1, 'hFF, 5, 1));
        bus_cycle(K_MRD, 16'h1234, 8'h00, 0, 8'h5A);

        q0.push_back(mk(6, 1, 1, 'h00FE, 'hC3, 0, 0, 7, 0));
        q1.push_back(mk(4, 1, 1, 'h00FE, 'hC3, 0, 0, 5, 1));
        bus_cycle(K_IOWR, 16'h00FE, 8'hC3, 5, 8'h00);

        int_vector = 8'hFF;
        q0.push_back(mk(0, 0, 0, 0, 0, 1, 'hFF, 2, 0));
        q1.push_back(mk(0, 0, 0, 0, 0, 1, 'hFF, 4, 0));
        bus_cycle(K_INTA, 16'h0038, 8'h00, 0, 8'h00);

        int_vector = 8'hA7;
        q0.push_back(mk(0, 0, 0, 0, 0, 1, 'hA7, 2, 0));
        q1.push_back(mk(0, 0, 0, 0, 0, 1, 'hA7, 4, 0));
        bus_cycle(K_INTA, 16'h0038, 8'h00, 0, 8'h00);

        q0.push_back(mk(16, 0, 0, 'h4000, 0, 1, 'hFF, 17, 1));
        q1.push_back(mk(4, 0, 0, 'h4000, 0, 1, 'hFF, 5, 1));
        bus_cycle(K_MRD, 16'h4000, 8'h00, -1, 8'h00);

        q0.push_back(mk(16, 0, 0, 'h2222, 0, 1, 'hE1, 17, 0));
        q1.push_back(mk(4, 0, 0, 'h2222, 0, 1, 'hFF, 5, 1));
        bus_cycle(K_MRD, 16'h2222, 8'h00, 15, 8'hE1);

        q0.push_back(mk(1, 1, 0, 'h8001, 'h5E, 0, 0, 2, 0));
        q1.push_back(mk(4, 1, 0, 'h8001, 'h5E, 0, 0, 5, 1));
        bus_cycle(K_MWR, 16'h8001, 8'h5E, 0, 8'h00);

        q0.push_back(mk(2, 0, 0, 'h0102, 0, 1, 'h77, 3, 0));
        q1.push_back(mk(4, 0, 0, 'h0102, 0, 1, 'hFF, 5, 1));
        bus_cycle(K_MRW, 16'h0102, 8'h99, 1, 8'h77);

        q0.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        q1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        short_cycle(1'b1, 16'h007F);

        q0.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        q1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        short_cycle(1'b0, 16'h3000);

        ack_dly = 3;
        rdata_val = 8'h11;
        @(posedge clk); #1;
        a = 16'h5555;
        n_mreq = 1'b0;
        n_rd = 1'b0;
        n = 0;
        while (!mem_req[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reset_test_req_seen", int'(mem_req[0]), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        set_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("midreset_mem_req", int'(mem_req[k]), 0);
            check("midreset_nwait", int'(n_wait[k]), 1);
            check("midreset_d_oe", int'(d_oe[k]), 0);
        end
        repeat (2) @(posedge clk);

        q0.push_back(mk(3, 0, 0, 'hBEEF, 0, 1, 'h3C, 4, 0));
        q1.push_back(mk(4, 0, 0, 'hBEEF, 0, 1, 'hFF, 5, 1));
        bus_cycle(K_MRD, 16'hBEEF, 8'h00, 2, 8'h3C);

        repeat (5) @(posedge clk);
        check("queue_drained", q0.size() + q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

endmodule
